// File: rtl/data_whiting_param.sv
// data_whiting_param: frame whitener. Each frame word after a run of
// unwhitened padding words is XORed with a DATA_W-bit mask taken from a
// Fibonacci LFSR. The LFSR is loaded from a per-frame seed on the start
// word. All outputs are registered with exactly one cycle of latency.
module data_whiting_param #(
  parameter int unsigned           DATA_W  = 8,
  parameter int unsigned           LFSR_W  = 9,
  parameter logic [LFSR_W-1:0]     TAPS    = 9'h021,
  parameter int unsigned           PAD_LEN = 80
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              indicator,
  input  logic [LFSR_W-1:0] seed,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              next_indicator
);

  // A zero-length pad still needs a 1-bit counter so the declaration stays legal.
  localparam int unsigned CNT_W    = (PAD_LEN == 0) ? 1 : $clog2(PAD_LEN + 1);
  localparam int unsigned PAD_LAST = (PAD_LEN == 0) ? 0 : PAD_LEN - 1;

  typedef enum logic [1:0] {
    IDLE,
    PAD,
    WHITEN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  pad_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [DATA_W-1:0] mask;

  // Unroll DATA_W LFSR steps: mask bit k is r[0] emitted at step k.
  always_comb begin
    logic [LFSR_W-1:0] r;
    logic              fb;
    r    = lfsr;
    fb   = 1'b0;
    mask = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      mask[k] = r[0];
      fb      = ^(r & TAPS);
      r       = {fb, r[LFSR_W-1:1]};
    end
    lfsr_adv = r;
  end

  // Frame state machine with registered output word and qualifiers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pad_cnt        <= '0;
      lfsr           <= '1;
      dout           <= '0;
      dout_valid     <= 1'b0;
      next_indicator <= 1'b0;
    end else begin
      dout_valid     <= din_valid;
      next_indicator <= din_valid & indicator;
      dout           <= din;
      if (din_valid) begin
        case (state)
          IDLE: begin
            if (indicator) begin
              lfsr    <= seed;
              pad_cnt <= '0;
              state   <= (PAD_LEN == 0) ? WHITEN : PAD;
            end
          end
          PAD: begin
            if (indicator) begin
              state <= IDLE;
            end else begin
              pad_cnt <= pad_cnt + CNT_W'(1);
              if (pad_cnt == CNT_W'(PAD_LAST)) state <= WHITEN;
            end
          end
          WHITEN: begin
            dout <= din ^ mask;
            lfsr <= lfsr_adv;
            if (indicator) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_whiting_param.sv
// tb_data_whiting_param: directed vectors for the frame whitener with
// hand-computed masks (seed 0x1FF -> FF, E1, 1D), plus hand-written
// sequences for reset behaviour and the PAD_LEN=0 variant.
module tb_data_whiting_param;

  logic       clk;
  logic       reset_n;
  logic [7:0] din;
  logic       din_valid;
  logic       indicator;
  logic [8:0] seed;
  logic [7:0] dout,  dout0;
  logic       dout_valid, dout_valid0;
  logic       next_indicator, next_indicator0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       i;
    logic [8:0] s;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_ind;
  } vec_t;

  vec_t vecs[$];

  data_whiting_param #(
    .DATA_W(8), .LFSR_W(9), .TAPS(9'h021), .PAD_LEN(80)
  ) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .indicator(indicator), .seed(seed), .dout(dout),
    .dout_valid(dout_valid), .next_indicator(next_indicator)
  );

  data_whiting_param #(
    .DATA_W(8), .LFSR_W(9), .TAPS(9'h021), .PAD_LEN(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .indicator(indicator), .seed(seed), .dout(dout0),
    .dout_valid(dout_valid0), .next_indicator(next_indicator0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic v, input logic i, input logic [8:0] s);
    din = d; din_valid = v; indicator = i; seed = s;
    @(posedge clk); #1;
  endtask

  function automatic void add(input logic [7:0] d, input logic v, input logic i,
                              input logic [8:0] s, input logic [7:0] e, input logic ei);
    vec_t t;
    t.d = d; t.v = v; t.i = i; t.s = s;
    t.exp_dout = e; t.exp_valid = v; t.exp_ind = ei;
    vecs.push_back(t);
  endfunction

  // start word + 80 pad words (seed on pads is 0 so a wrong capture shows up)
  function automatic void add_start_pad(input logic [8:0] s);
    add(8'h00, 1, 1, s, 8'h00, 1);
    for (int k = 0; k < 80; k++) add(8'h00, 1, 0, 9'h000, 8'h00, 0);
  endfunction

  initial begin
    din = '0; din_valid = 0; indicator = 0; seed = '0;
    reset_n = 1'b1;

    // ---- vector table ----
    // default frame, third whitened word ends the frame
    add_start_pad(9'h1FF);
    add(8'h00, 1, 0, 9'h000, 8'hFF, 0);
    add(8'h00, 1, 0, 9'h000, 8'hE1, 0);
    add(8'h00, 1, 1, 9'h000, 8'h1D, 1);
    // after frame end: passes unchanged; invalid start marker is ignored
    add(8'h33, 1, 0, 9'h000, 8'h33, 0);
    add(8'hA5, 0, 1, 9'h000, 8'hA5, 0);
    // restart reproduces mask FF from fresh seed
    add_start_pad(9'h1FF);
    add(8'h0F, 1, 0, 9'h000, 8'hF0, 0);
    add(8'h00, 1, 1, 9'h000, 8'hE1, 1);
    // stalled frame: gaps of 1-3 cycles, including one inside padding
    add(8'h00, 1, 1, 9'h1FF, 8'h00, 1);
    for (int k = 0; k < 40; k++) add(8'h00, 1, 0, 9'h000, 8'h00, 0);
    add(8'h77, 0, 0, 9'h000, 8'h77, 0);
    for (int k = 0; k < 40; k++) add(8'h00, 1, 0, 9'h000, 8'h00, 0);
    add(8'h00, 1, 0, 9'h000, 8'hFF, 0);
    add(8'h12, 0, 0, 9'h000, 8'h12, 0);
    add(8'h00, 1, 0, 9'h000, 8'hE1, 0);
    add(8'h34, 0, 0, 9'h000, 8'h34, 0);
    add(8'h56, 0, 1, 9'h000, 8'h56, 0);
    add(8'h78, 0, 0, 9'h000, 8'h78, 0);
    add(8'h00, 1, 1, 9'h000, 8'h1D, 1);
    // abort on pad word 10, then 90 words stay unwhitened
    add(8'h00, 1, 1, 9'h1FF, 8'h00, 1);
    for (int k = 1; k < 10; k++) add(8'h00, 1, 0, 9'h000, 8'h00, 0);
    add(8'hC3, 1, 1, 9'h000, 8'hC3, 1);
    for (int k = 0; k < 90; k++) add(8'h00, 1, 0, 9'h000, 8'h00, 0);
    add(8'h99, 1, 0, 9'h000, 8'h99, 0);

    // ---- reset values ----
    #2 reset_n = 1'b0;
    #1;
    check("reset_dout", dout, 8'h00);
    check("reset_valid", dout_valid, 1'b0);
    check("reset_ind", next_indicator, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    apply(8'h5A, 1, 0, 9'h000);
    check("post_reset_dout", dout, 8'h5A);
    check("post_reset_valid", dout_valid, 1'b1);
    apply(8'h3C, 1, 0, 9'h000);
    check("idle_pass_dout", dout, 8'h3C);
    // asynchronous clear mid-stream
    #2 reset_n = 1'b0;
    #1;
    check("async_dout", dout, 8'h00);
    check("async_valid", dout_valid, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    // ---- table-driven vectors ----
    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].d, vecs[n].v, vecs[n].i, vecs[n].s);
      checks++;
      if (dout !== vecs[n].exp_dout || dout_valid !== vecs[n].exp_valid ||
          next_indicator !== vecs[n].exp_ind) begin
        errors++;
        $display("FAIL vec[%0d]: got dout=%0h v=%0b ind=%0b expected dout=%0h v=%0b ind=%0b",
                 n, dout, dout_valid, next_indicator,
                 vecs[n].exp_dout, vecs[n].exp_valid, vecs[n].exp_ind);
      end
    end

    // ---- mid-frame reset ----
    apply(8'h00, 1, 1, 9'h1FF);
    for (int k = 0; k < 80; k++) apply(8'h00, 1, 0, 9'h000);
    apply(8'h00, 1, 0, 9'h000);
    check("mf_w0", dout, 8'hFF);
    apply(8'h00, 1, 0, 9'h000);
    check("mf_w1", dout, 8'hE1);
    #2 reset_n = 1'b0;
    #1;
    check("mf_rst_dout", dout, 8'h00);
    check("mf_rst_valid", dout_valid, 1'b0);
    check("mf_rst_ind", next_indicator, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    // no fresh start: word passes unchanged
    apply(8'h00, 1, 0, 9'h000);
    check("mf_nostart", dout, 8'h00);

    // ---- new frame after reset; also exercises the PAD_LEN=0 instance ----
    // (dut0 has just been reset too, so it is in IDLE)
    apply(8'h00, 1, 1, 9'h1FF);
    check("p0_start_dout", dout0, 8'h00);
    check("p0_start_ind", next_indicator0, 1'b1);
    apply(8'h00, 1, 0, 9'h000);
    check("p0_first", dout0, 8'hFF);
    check("p80_pad", dout, 8'h00);
    apply(8'h00, 1, 0, 9'h000);
    check("p0_second", dout0, 8'hE1);
    for (int k = 0; k < 78; k++) apply(8'h00, 1, 0, 9'h000);
    check("p80_lastpad", dout, 8'h00);
    apply(8'h00, 1, 0, 9'h000);
    check("mf_new_w0", dout, 8'hFF);
    check("mf_new_valid", dout_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_whiting_param.md
# data_whiting_param

Parametrised frame whitener for the framing/encoding chain: XORs each data word of a frame with a word-wide mask from a configurable Fibonacci LFSR, after a configurable run of unwhitened padding words. Unlike the earlier fixed 8-bit, one-bit-per-cycle whitener, it has:
- a valid qualifier with stall support;
- generation of a full DATA_W-bit mask per accepted word;
- a per-frame seed;
- registered outputs.

It sits between the framer and the line encoder and passes the frame indicator through, aligned to the data.

## Interface
- DATA_W, 8: data word width.
- LFSR_W, 9: LFSR length.
- TAPS, 9'h021: feedback tap mask; bit i set means r[i] is XORed into the feedback.
- PAD_LEN, 80: number of valid words passed unwhitened after the start indicator; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  input word.
- din_valid  in  1  din, indicator and seed are meaningful this cycle.
- indicator  in  1  frame start/stop marker; sampled only when din_valid=1.
- seed  in  LFSR_W  LFSR seed, captured on the start word.
- dout  out  DATA_W  registered output word.
- dout_valid  out  1  registered copy of din_valid.
- next_indicator  out  1  registered copy of (indicator & din_valid).

## Operation
- **LFSR step:**
  - f = XOR of r[i] over all i with TAPS[i]=1.
  - r_next = {f, r[LFSR_W-1:1]}.
  - Each step emits r[0].
- **Word mask:** mask[k] = bit emitted at step k, for k = 0..DATA_W-1. Computed combinationally by unrolling DATA_W steps. After each whitened word the LFSR advances exactly DATA_W steps.
- **IDLE** (after reset):
  - Words pass unchanged.
  - On a valid word with indicator=1: lfsr <= seed, pad_cnt <= 0, and the state moves to PAD, or to WHITEN if PAD_LEN==0.
  - The start word itself passes unchanged and is not counted as padding.
- **PAD:**
  - Each valid word passes unchanged; pad_cnt increments.
  - The word that makes pad_cnt reach PAD_LEN moves the state to WHITEN.
  - A valid word with indicator=1 aborts the frame: the word passes unchanged and the state returns to IDLE.
  - The LFSR holds throughout PAD.
- **WHITEN:**
  - Each valid word outputs din ^ mask(lfsr), and the LFSR advances DATA_W steps.
  - A valid word with indicator=1 is whitened as the last frame word, then the state returns to IDLE.
- **Invalid cycles:** cycles with din_valid=0 change no state, counter or LFSR. The output registers still load: dout = din unmodified, dout_valid = 0, next_indicator = 0.
- **Counter width:** pad_cnt is $clog2(PAD_LEN+1) bits and never wraps.
- **Restart:** a new frame always restarts from the seed sampled on its own start word.

## Timing
- **Latency:** exactly 1 cycle from din/din_valid/indicator to dout/dout_valid/next_indicator. No internal buffering.
- **Throughput:** one word per cycle, with no bubbles inserted.
- **Reset values:** dout=0, dout_valid=0, next_indicator=0, state=IDLE, pad_cnt=0, lfsr=all ones.
- **Reset mid-frame:** outputs clear immediately (asynchronously). The next frame requires a fresh start indicator.
- **Mask sequence:** with default parameters and seed=9'h1FF, the mask sequence is 0xFF, 0xE1, 0x1D, …

## Test plan
- **Reset values:** assert reset_n=0 mid-stream -> dout=0, dout_valid=0, next_indicator=0 at once. After release, din=0x5A valid gives dout=0x5A.
- **Default frame:**
  - Stimulus: start word 0x00 with indicator=1, seed=0x1FF, then 80 words 0x00, then words 0x00, 0x00, 0x00.
  - Response: start and pad words give dout=0x00; the next three give 0xFF, 0xE1, 0x1D, each one cycle after input.
- **Stalls:** same frame with din_valid=0 gaps of 1–3 cycles between whitened words -> identical mask sequence FF, E1, 1D. dout_valid=0 during gaps.
- **Frame end and restart:**
  - The third whitened word carries indicator=1 -> whitened (0x1D), next_indicator=1.
  - The following word passes unchanged.
  - A new start with seed=0x1FF reproduces 0xFF as the first mask.
- **Abort in PAD and PAD_LEN=0:**
  - Indicator on pad word 10 -> back to IDLE, later words unchanged.
  - Instance with PAD_LEN=0: the word right after start gives 0x00^0xFF=0xFF.
- **Mid-frame reset:** assert reset_n after 2 whitened words -> outputs 0. The subsequent frame's first whitened word again uses mask 0xFF.
